// File: rtl/writeback_arbiter_l4.sv
// writeback_arbiter_l4: arbitrates p_num_units execute-unit results onto one RF write port + commit report.
// Latency: 1 cycle from x_val&x_rdy transfer to commit_val/rf_* outputs.
// Backpressure: never stalls; one grant per cycle, losers wait with x_val high and a stable payload.
//
// Ports:
//   clk, rst                     clock; synchronous active-high reset
//   x_val/x_rdy                  per-unit valid in, one-hot grant out (combinational)
//   x_pc/x_seq_num/x_waddr/
//   x_wdata/x_wen                per-unit result payload
//   rf_wen/rf_waddr/rf_wdata     register-file write port (x0 writes suppressed)
//   commit_val/commit_pc/
//   commit_seq_num               retired-instruction report
//
// Build option: define WB_RR_ARB_EN for round-robin arbitration starting at the
// pointer index; otherwise the lowest valid index wins (fixed priority).
module writeback_arbiter_l4 #(
  parameter int p_num_units    = 4,
  parameter int p_seq_num_bits = 5
) (
  input  logic                                         clk,
  input  logic                                         rst,
  input  logic [p_num_units-1:0]                       x_val,
  output logic [p_num_units-1:0]                       x_rdy,
  input  logic [p_num_units-1:0][31:0]                 x_pc,
  input  logic [p_num_units-1:0][p_seq_num_bits-1:0]   x_seq_num,
  input  logic [p_num_units-1:0][4:0]                  x_waddr,
  input  logic [p_num_units-1:0][31:0]                 x_wdata,
  input  logic [p_num_units-1:0]                       x_wen,
  output logic                                         rf_wen,
  output logic [4:0]                                   rf_waddr,
  output logic [31:0]                                  rf_wdata,
  output logic                                         commit_val,
  output logic [31:0]                                  commit_pc,
  output logic [p_seq_num_bits-1:0]                    commit_seq_num
);

  // Captured result of the winning unit.
  typedef struct packed {
    logic                      val;
    logic [31:0]               pc;
    logic [p_seq_num_bits-1:0] seq;
    logic [4:0]                waddr;
    logic [31:0]               wdata;
    logic                      wen;
  } wb_t;

  wb_t                    out_d, out_q;
  logic [p_num_units-1:0] grant;
  logic                   found;

`ifdef WB_RR_ARB_EN
  localparam int PTR_W = (p_num_units > 1) ? $clog2(p_num_units) : 1;
  logic [PTR_W-1:0] ptr_d, ptr_q;

  // Round robin: scan indices >= pointer first, then wrap to indices below it.
  always_comb begin
    grant = '0;
    found = 1'b0;
    for (int i = 0; i < p_num_units; i++) begin
      if (!found && x_val[i] && (i >= int'(ptr_q))) begin
        grant[i] = 1'b1;
        found    = 1'b1;
      end
    end
    for (int i = 0; i < p_num_units; i++) begin
      if (!found && x_val[i] && (i < int'(ptr_q))) begin
        grant[i] = 1'b1;
        found    = 1'b1;
      end
    end
    if (rst) begin
      grant = '0;
    end
  end

  // Pointer moves only on a transfer, to the slot after the winner.
  always_comb begin
    ptr_d = ptr_q;
    for (int i = 0; i < p_num_units; i++) begin
      if (grant[i]) begin
        ptr_d = (i == p_num_units - 1) ? '0 : PTR_W'(i + 1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ptr_q <= '0;
    end else begin
      ptr_q <= ptr_d;
    end
  end
`else
  // Fixed priority: lowest valid index wins.
  always_comb begin
    grant = '0;
    found = 1'b0;
    for (int i = 0; i < p_num_units; i++) begin
      if (!found && x_val[i]) begin
        grant[i] = 1'b1;
        found    = 1'b1;
      end
    end
    if (rst) begin
      grant = '0;
    end
  end
`endif

  assign x_rdy = grant;

  // Payload fields hold when nothing transfers so rf_waddr/rf_wdata stay put.
  always_comb begin
    out_d     = out_q;
    out_d.val = 1'b0;
    for (int i = 0; i < p_num_units; i++) begin
      if (grant[i]) begin
        out_d.val   = 1'b1;
        out_d.pc    = x_pc[i];
        out_d.seq   = x_seq_num[i];
        out_d.waddr = x_waddr[i];
        out_d.wdata = x_wdata[i];
        out_d.wen   = x_wen[i];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      out_q.val <= 1'b0;
    end else begin
      out_q <= out_d;
    end
  end

  // Gating with rst keeps commit/write quiet during the whole reset cycle,
  // not just after the first reset edge.
  assign commit_val     = out_q.val & ~rst;
  assign commit_pc      = out_q.pc;
  assign commit_seq_num = out_q.seq;
  assign rf_waddr       = out_q.waddr;
  assign rf_wdata       = out_q.wdata;
  assign rf_wen         = commit_val & out_q.wen & (out_q.waddr != 5'd0);

endmodule

// File: tb/tb_writeback_arbiter_l4.sv
module tb_writeback_arbiter_l4;

  localparam int N = 4;
  localparam int S = 5;

  logic                  clk = 1'b0;
  logic                  rst;
  logic [N-1:0]          x_val;
  logic [N-1:0]          x_rdy;
  logic [N-1:0][31:0]    x_pc;
  logic [N-1:0][S-1:0]   x_seq_num;
  logic [N-1:0][4:0]     x_waddr;
  logic [N-1:0][31:0]    x_wdata;
  logic [N-1:0]          x_wen;
  logic                  rf_wen;
  logic [4:0]            rf_waddr;
  logic [31:0]           rf_wdata;
  logic                  commit_val;
  logic [31:0]           commit_pc;
  logic [S-1:0]          commit_seq_num;

  always #5 clk = ~clk;

  writeback_arbiter_l4 #(.p_num_units(N), .p_seq_num_bits(S)) dut (
    .clk(clk), .rst(rst),
    .x_val(x_val), .x_rdy(x_rdy),
    .x_pc(x_pc), .x_seq_num(x_seq_num), .x_waddr(x_waddr),
    .x_wdata(x_wdata), .x_wen(x_wen),
    .rf_wen(rf_wen), .rf_waddr(rf_waddr), .rf_wdata(rf_wdata),
    .commit_val(commit_val), .commit_pc(commit_pc), .commit_seq_num(commit_seq_num)
  );

  typedef struct {
    logic        val;
    logic [31:0] pc;
    logic [S-1:0] seq;
    logic        rf_wen;
    logic        chk_hold;
    logic [4:0]  waddr;
    logic [31:0] wdata;
  } exp_t;

  exp_t        sb[$];
  int          pass_cnt = 0;
  int          tot_cnt  = 0;
  int          fail_cnt = 0;
  logic        have_last = 1'b0;
  logic [4:0]  last_waddr = '0;
  logic [31:0] last_wdata = '0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tot_cnt++;
    assert (obs === exp) pass_cnt++;
    else begin
      fail_cnt++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // One clock: drive inputs, check the grant mid-cycle, record the expected
  // commit, then compare the registered outputs after the edge.
  task automatic step(input string tag, input logic r, input logic [N-1:0] v,
                      input logic [N-1:0] exp_rdy);
    exp_t e;
    exp_t got;
    int   g;
    rst   = r;
    x_val = v;
    @(negedge clk);
    chk({tag, ".x_rdy"}, 64'(x_rdy), 64'(exp_rdy));
    if (r) begin
      chk({tag, ".rst_commit_val"}, 64'(commit_val), 64'd0);
      chk({tag, ".rst_rf_wen"}, 64'(rf_wen), 64'd0);
    end
    g = -1;
    for (int i = 0; i < N; i++) if (exp_rdy[i]) g = i;
    e = '{val: 1'b0, pc: '0, seq: '0, rf_wen: 1'b0, chk_hold: 1'b0, waddr: '0, wdata: '0};
    if (r) begin
      have_last = 1'b0;
    end else if (g >= 0) begin
      e.val      = 1'b1;
      e.pc       = x_pc[g];
      e.seq      = x_seq_num[g];
      e.rf_wen   = x_wen[g] && (x_waddr[g] != 5'd0);
      e.chk_hold = 1'b1;
      e.waddr    = x_waddr[g];
      e.wdata    = x_wdata[g];
      have_last  = 1'b1;
      last_waddr = x_waddr[g];
      last_wdata = x_wdata[g];
    end else if (have_last) begin
      e.chk_hold = 1'b1;
      e.waddr    = last_waddr;
      e.wdata    = last_wdata;
    end
    sb.push_back(e);
    @(posedge clk);
    #1;
    if (sb.size() == 0) begin
      chk({tag, ".sb_empty"}, 64'd0, 64'd1);
    end else begin
      got = sb.pop_front();
      chk({tag, ".commit_val"}, 64'(commit_val), 64'(got.val));
      chk({tag, ".rf_wen"}, 64'(rf_wen), 64'(got.rf_wen));
      if (got.val) begin
        chk({tag, ".commit_pc"}, 64'(commit_pc), 64'(got.pc));
        chk({tag, ".commit_seq"}, 64'(commit_seq_num), 64'(got.seq));
      end
      if (got.chk_hold) begin
        chk({tag, ".rf_waddr"}, 64'(rf_waddr), 64'(got.waddr));
        chk({tag, ".rf_wdata"}, 64'(rf_wdata), 64'(got.wdata));
      end
    end
    // A granted unit moves on to a fresh result; losers keep theirs stable.
    if (!r && g >= 0) begin
      x_pc[g]      = x_pc[g] + 32'd4;
      x_seq_num[g] = x_seq_num[g] + 1'b1;
      x_wdata[g]   = (x_wdata[g] ^ 32'h1234_5678) + 32'(g);
    end
  endtask

  initial begin
    rst   = 1'b1;
    x_val = '0;
    x_pc[0] = 32'h0000_0000; x_seq_num[0] = 5'd0;  x_waddr[0] = 5'd1;  x_wdata[0] = 32'h1111_0000; x_wen[0] = 1'b1;
    x_pc[1] = 32'h0000_0100; x_seq_num[1] = 5'd10; x_waddr[1] = 5'd7;  x_wdata[1] = 32'h2222_0000; x_wen[1] = 1'b1;
    x_pc[2] = 32'h0000_0200; x_seq_num[2] = 5'd3;  x_waddr[2] = 5'd5;  x_wdata[2] = 32'hDEAD_BEEF; x_wen[2] = 1'b1;
    x_pc[3] = 32'h0000_0300; x_seq_num[3] = 5'd20; x_waddr[3] = 5'd31; x_wdata[3] = 32'h3333_0000; x_wen[3] = 1'b1;
    #1;

    // Reset with all units requesting: nothing granted, nothing committed.
    step("rst0", 1'b1, 4'b1111, 4'b0000);
    step("rst1", 1'b1, 4'b1111, 4'b0000);

    // Single unit 2 with the reference payload.
    step("u2_single", 1'b0, 4'b0100, 4'b0100);
    // Write to x0 commits but is not written.
    x_waddr[0] = 5'd0;
    step("u0_x0", 1'b0, 4'b0001, 4'b0001);
    x_waddr[0] = 5'd1;
    // Idle: no grant, val drops, write port holds last values.
    step("idle", 1'b0, 4'b0000, 4'b0000);
    // wen low: commit without a register write.
    x_wen[1] = 1'b0;
    step("u1_nowen", 1'b0, 4'b0010, 4'b0010);
    x_wen[1] = 1'b1;

    // All units valid for 8 cycles straight out of reset.
    step("rst_all", 1'b1, 4'b0000, 4'b0000);
    for (int c = 0; c < 8; c++) begin
`ifdef WB_RR_ARB_EN
      step($sformatf("all_%0d", c), 1'b0, 4'b1111, 4'(1 << (c % 4)));
`else
      step($sformatf("all_%0d", c), 1'b0, 4'b1111, 4'b0001);
`endif
    end

    // Move the pointer to 2 via unit 1, then units 1 and 3 compete.
    step("u1_ptr2", 1'b0, 4'b0010, 4'b0010);
`ifdef WB_RR_ARB_EN
    step("u13_a", 1'b0, 4'b1010, 4'b1000);
    step("u13_b", 1'b0, 4'b1010, 4'b0010);
`else
    step("u13_a", 1'b0, 4'b1010, 4'b0010);
    step("u13_b", 1'b0, 4'b1010, 4'b0010);
`endif

    // Reset pulse during a pending transfer; pointer returns to 0
    // (left at 2 by the last unit 1 grant).
    step("rst_mid", 1'b1, 4'b1111, 4'b0000);
    step("post_rst", 1'b0, 4'b1111, 4'b0001);
    step("tail_idle", 1'b0, 4'b0000, 4'b0000);

    $display("%0d/%0d checks passed", pass_cnt, tot_cnt);
    $finish;
  end

endmodule
